// File: rtl/add_seq_ctrl.sv
// Multi-word add sequencer: one shared 32-bit ripple-carry adder walks WORDS slices LSW first.
// Optional subtract mode (a - b) is enabled by defining ADD_SEQ_SUB_EN.

module rca32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [32:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 32; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[32];
  end

endmodule

module add_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [32*WORDS-1:0]   a,
  input  logic [32*WORDS-1:0]   b,
  input  logic                  ci,
`ifdef ADD_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [32*WORDS-1:0]   s,
  output logic                  co
);

  localparam int W     = 32 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [W-1:0]     a_reg, b_reg;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [31:0]      a_slice, b_slice, sum_slice;
  logic             co_slice;
`ifdef ADD_SEQ_SUB_EN
  logic             sub_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // DONE accepts a new start exactly like IDLE so back-to-back ops lose no cycle
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ADD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_slice = a_reg[{idx, 5'd0} +: 32];
`ifdef ADD_SEQ_SUB_EN
    b_slice = b_reg[{idx, 5'd0} +: 32] ^ {32{sub_reg}};
`else
    b_slice = b_reg[{idx, 5'd0} +: 32];
`endif
  end

  rca32 u_rca32 (
    .a  (a_slice),
    .b  (b_slice),
    .ci (carry),
    .s  (sum_slice),
    .co (co_slice)
  );

  // Operand capture, then one slice written per ADD cycle with the carry chained
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      s       <= '0;
      co      <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
      sub_reg <= 1'b0;
`endif
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      idx     <= '0;
`ifdef ADD_SEQ_SUB_EN
      sub_reg <= sub;
      carry   <= sub | ci;
`else
      carry   <= ci;
`endif
    end else if (state == ADD) begin
      s[{idx, 5'd0} +: 32] <= sum_slice;
      carry                <= co_slice;
      if (idx == LAST_IDX) begin
        co  <= co_slice;
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule
